// File: rtl/uart_prog_pkg.sv
// Shared types and defaults for the UART program loader.
package uart_prog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [31:0] END_MARKER_DEF  = 32'h0000_0FFF;
    localparam logic [15:0] DEFAULT_CPB_DEF = 16'd87;
    localparam logic [15:0] CPB_MIN         = 16'd2;

    // The UART RX cannot sample mid-bit with fewer than two clocks per bit.
    function automatic logic [15:0] clamp_cpb(input logic [15:0] v);
        return (v < CPB_MIN) ? CPB_MIN : v;
    endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// Packs received bytes little-endian into 32-bit words. The completed word and its
// valid pulse are presented in the same cycle as the fourth byte.
module uart_word_assembler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        dv_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_vld_o
);

    logic [1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (dv_i) begin
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       hit;
            logic [7:0] lane_q;

            assign hit = dv_i && (idx_q == 2'(gi));

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    lane_q <= '0;
                end else if (clr_i) begin
                    lane_q <= '0;
                end else if (hit) begin
                    lane_q <= byte_i;
                end
            end

            // Bypass the incoming byte so the word is usable in its arrival cycle.
            assign word_o[8*gi +: 8] = hit ? byte_i : lane_q;
        end
    endgenerate

    assign word_vld_o = dv_i && (idx_q == 2'd3) && !clr_i;

endmodule

// File: rtl/uart_prog_loader.sv
// Boot-time sequencer: sets the UART baud divisor, assembles received words and
// writes them to instruction memory, holding the core in reset until the end marker.
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [15:0]       DEFAULT_CPB = DEFAULT_CPB_DEF,
    parameter logic [31:0]       END_MARKER  = END_MARKER_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              prog_en_i,
    input  logic              cfg_we_i,
    input  logic [15:0]       cfg_cpb_i,
    output logic [15:0]       clks_per_bit_o,
    input  logic              rx_dv_i,
    input  logic [7:0]        rx_byte_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o,
    output logic [ADDR_W-1:0] word_cnt_o
);

    state_e            state_q, state_d;
    logic [15:0]       cpb_q, cpb_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic        asm_clr, asm_dv, word_vld, granted;
    logic [31:0] word;

    assign asm_clr = (state_q == IDLE) && prog_en_i;
    assign asm_dv  = (state_q == RECV) && rx_dv_i;
    assign granted = req_q && mem_gnt_i;

    uart_word_assembler u_asm (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (asm_clr),
        .dv_i       (asm_dv),
        .byte_i     (rx_byte_i),
        .word_o     (word),
        .word_vld_o (word_vld)
    );

    always_comb begin
        state_d   = state_q;
        cpb_d     = cpb_q;
        req_d     = req_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;

        if (granted) begin
            req_d  = 1'b0;
            addr_d = addr_q + ADDR_W'(4);
            cnt_d  = cnt_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cfg_we_i) begin
                    cpb_d = clamp_cpb(cfg_cpb_i);
                end
                if (prog_en_i) begin
                    state_d   = RECV;
                    addr_d    = BASE_ADDR;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            RECV: begin
                if (word_vld) begin
                    if (word == END_MARKER) begin
                        state_d = DRAIN;
                    end else if (!req_q || mem_gnt_i) begin
                        // A grant this cycle frees the slot in time for the new word.
                        wdata_d = word;
                        req_d   = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!req_q || mem_gnt_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!prog_en_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        core_rst_n_d = (state_d == IDLE) || (state_d == DONE);
        busy_d       = (state_d == RECV) || (state_d == DRAIN);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cpb_q        <= DEFAULT_CPB;
            req_q        <= 1'b0;
            addr_q       <= BASE_ADDR;
            wdata_q      <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            cpb_q        <= cpb_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            cnt_q        <= cnt_d;
        end
    end

    assign clks_per_bit_o = cpb_q;
    assign mem_req_o      = req_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign core_rst_no    = core_rst_n_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign overrun_o      = overrun_q;
    assign word_cnt_o     = cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scenario-based bench for uart_prog_loader: a memory-side monitor records every
// granted write and each scenario compares it against the words it sent.
module tb_uart_prog_loader;

    localparam int              ADDR_W  = 16;
    localparam logic [15:0]     BASE    = 16'h0000;
    localparam logic [31:0]     MARK    = 32'h0000_0FFF;
    localparam logic [15:0]     DEF_CPB = 16'd87;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              prog_en_i;
    logic              cfg_we_i;
    logic [15:0]       cfg_cpb_i;
    logic [15:0]       clks_per_bit_o;
    logic              rx_dv_i;
    logic [7:0]        rx_byte_i;
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              core_rst_no;
    logic              busy_o;
    logic              done_o;
    logic              overrun_o;
    logic [ADDR_W-1:0] word_cnt_o;

    int tests = 0;
    int fails = 0;

    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] exp_q[$];

    uart_prog_loader #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE),
        .DEFAULT_CPB (DEF_CPB),
        .END_MARKER  (MARK)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .prog_en_i      (prog_en_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_cpb_i      (cfg_cpb_i),
        .clks_per_bit_o (clks_per_bit_o),
        .rx_dv_i        (rx_dv_i),
        .rx_byte_i      (rx_byte_i),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .core_rst_no    (core_rst_no),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overrun_o      (overrun_o),
        .word_cnt_o     (word_cnt_o)
    );

    always #5 clk = ~clk;

    // Memory side: a write happens on every edge that sees req and gnt together.
    always @(posedge clk) begin
        if (mem_req_o === 1'b1 && mem_gnt_i === 1'b1) begin
            wa_q.push_back(mem_addr_o);
            wd_q.push_back(mem_wdata_o);
            $display("[TB] write addr=%h data=%h", mem_addr_o, mem_wdata_o);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv_i   = 1'b1;
        rx_byte_i = b;
        tick();
        rx_dv_i   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (i != 3) repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == MARK) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic enter_prog();
        wa_q.delete();
        wd_q.delete();
        exp_q.delete();
        prog_en_i = 1'b1;
        tick();
    endtask

    task automatic finish_prog();
        int n;
        send_word(MARK, 0);
        n = 0;
        while (done_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (done_o !== 1'b1 || core_rst_no !== 1'b1) begin
            fails++;
            $display("FAIL done_after_marker: done=%b core_rst_n=%b required 1/1", done_o, core_rst_no);
        end
        $display("[TB] program done, %0d writes seen", wa_q.size());
    endtask

    task automatic leave_prog();
        prog_en_i = 1'b0;
        tick();
        tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || core_rst_no !== 1'b1) begin
            fails++;
            $display("FAIL leave_to_idle: done=%b busy=%b core_rst_n=%b required 0/0/1", done_o, busy_o, core_rst_no);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; prog_en_i = 1'b0; cfg_we_i = 1'b0; cfg_cpb_i = '0;
        rx_dv_i = 1'b0; rx_byte_i = '0; mem_gnt_i = 1'b0;
        repeat (2) tick();
        tests++;
        if (clks_per_bit_o !== DEF_CPB || mem_req_o !== 1'b0 || mem_addr_o !== BASE ||
            mem_wdata_o !== 32'h0 || core_rst_no !== 1'b0 || busy_o !== 1'b0 ||
            done_o !== 1'b0 || overrun_o !== 1'b0 || word_cnt_o !== '0) begin
            fails++;
            $display("FAIL reset_values: cpb=%0d req=%b addr=%h wdata=%h crst=%b busy=%b done=%b ovr=%b cnt=%0d",
                     clks_per_bit_o, mem_req_o, mem_addr_o, mem_wdata_o, core_rst_no, busy_o, done_o, overrun_o, word_cnt_o);
        end
        rst_ni = 1'b1;
        tick();
        tests++;
        if (core_rst_no !== 1'b1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: core_rst_n=%b busy=%b required 1/0", core_rst_no, busy_o);
        end
    endtask

    task automatic test_cfg();
        logic [15:0] v;
        logic [15:0] vals[3];
        logic [15:0] expv[3];
        v = 16'($urandom_range(2, 65535));
        vals[0] = 16'd1; expv[0] = 16'd2;
        vals[1] = 16'd0; expv[1] = 16'd2;
        vals[2] = v;     expv[2] = v;
        for (int i = 0; i < 3; i++) begin
            cfg_we_i = 1'b1; cfg_cpb_i = vals[i];
            tick();
            cfg_we_i = 1'b0;
            tests++;
            if (clks_per_bit_o !== expv[i]) begin
                fails++;
                $display("FAIL cfg_idle: wrote %0d got %0d required %0d", vals[i], clks_per_bit_o, expv[i]);
            end
            $display("[TB] cfg write %0d -> cpb %0d", vals[i], clks_per_bit_o);
        end
        enter_prog();
        cfg_we_i = 1'b1; cfg_cpb_i = 16'd434;
        tick();
        cfg_we_i = 1'b0;
        tests++;
        if (clks_per_bit_o !== v) begin
            fails++;
            $display("FAIL cfg_in_recv: got %0d required %0d", clks_per_bit_o, v);
        end
        finish_prog();
        leave_prog();
    endtask

    task automatic test_single_word();
        mem_gnt_i = 1'b1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        enter_prog();
        tests++;
        if (busy_o !== 1'b1 || core_rst_no !== 1'b0 || mem_addr_o !== BASE || word_cnt_o !== '0) begin
            fails++;
            $display("FAIL enter_recv: busy=%b crst=%b addr=%h cnt=%0d required 1/0/%h/0", busy_o, core_rst_no, mem_addr_o, word_cnt_o, BASE);
        end
        send_word(32'h1234_5678, 1);
        tests++;
        if (mem_req_o !== 1'b1 || mem_wdata_o !== 32'h1234_5678 || mem_addr_o !== BASE) begin
            fails++;
            $display("FAIL single_req: req=%b data=%h addr=%h required 1/12345678/%h", mem_req_o, mem_wdata_o, mem_addr_o, BASE);
        end
        tick();
        tests++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== BASE + 16'd4 || word_cnt_o !== 16'd1 || core_rst_no !== 1'b0) begin
            fails++;
            $display("FAIL single_after_gnt: req=%b addr=%h cnt=%0d crst=%b required 0/%h/1/0", mem_req_o, mem_addr_o, word_cnt_o, core_rst_no, BASE + 16'd4);
        end
        tests++;
        if (wd_q.size() != 1 || wd_q[0] !== 32'h1234_5678 || wa_q[0] !== BASE) begin
            fails++;
            $display("FAIL single_write: %0d writes seen, required one of 12345678 at %h", wd_q.size(), BASE);
        end
        finish_prog();
        leave_prog();
    endtask

    task automatic test_program(input int n);
        mem_gnt_i = 1'b1;
        enter_prog();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(rand_word());
            send_word(exp_q[k], 2);
            repeat ($urandom_range(1, 3)) tick();
        end
        finish_prog();
        tests++;
        if (wd_q.size() != n || word_cnt_o !== 16'(n)) begin
            fails++;
            $display("FAIL prog_count: writes=%0d cnt=%0d required %0d", wd_q.size(), word_cnt_o, n);
        end
        for (int k = 0; k < n && k < wd_q.size(); k++) begin
            tests++;
            if (wd_q[k] !== exp_q[k] || wa_q[k] !== BASE + 16'(4 * k)) begin
                fails++;
                $display("FAIL prog_write[%0d]: got %h@%h required %h@%h", k, wd_q[k], wa_q[k], exp_q[k], BASE + 16'(4 * k));
            end
        end
        leave_prog();
    endtask

    task automatic test_overrun();
        logic [31:0] a, b;
        a = rand_word(); b = rand_word();
        mem_gnt_i = 1'b0;
        enter_prog();
        send_word(a, 1);
        tests++;
        if (mem_req_o !== 1'b1 || mem_wdata_o !== a) begin
            fails++;
            $display("FAIL ovr_first_req: req=%b data=%h required 1/%h", mem_req_o, mem_wdata_o, a);
        end
        send_word(b, 1);
        tick();
        tests++;
        if (overrun_o !== 1'b1 || mem_req_o !== 1'b1 || mem_wdata_o !== a || mem_addr_o !== BASE) begin
            fails++;
            $display("FAIL ovr_hold: ovr=%b req=%b data=%h addr=%h required 1/1/%h/%h", overrun_o, mem_req_o, mem_wdata_o, mem_addr_o, a, BASE);
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        tests++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== BASE + 16'd4 || word_cnt_o !== 16'd1 || overrun_o !== 1'b1) begin
            fails++;
            $display("FAIL ovr_grant: req=%b addr=%h cnt=%0d ovr=%b required 0/%h/1/1", mem_req_o, mem_addr_o, word_cnt_o, overrun_o, BASE + 16'd4);
        end
        finish_prog();
        tests++;
        if (wd_q.size() != 1 || wd_q[0] !== a) begin
            fails++;
            $display("FAIL ovr_writes: %0d writes seen, required exactly one of %h", wd_q.size(), a);
        end
        leave_prog();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        a = rand_word(); b = rand_word();
        mem_gnt_i = 1'b0;
        enter_prog();
        tests++;
        if (overrun_o !== 1'b0) begin
            fails++;
            $display("FAIL ovr_cleared_on_entry: got %b required 0", overrun_o);
        end
        send_word(a, 0);
        for (int i = 0; i < 3; i++) send_byte(b[8*i +: 8]);
        mem_gnt_i = 1'b1;
        send_byte(b[31:24]);
        tests++;
        if (mem_req_o !== 1'b1 || mem_wdata_o !== b || mem_addr_o !== BASE + 16'd4 ||
            word_cnt_o !== 16'd1 || overrun_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: req=%b data=%h addr=%h cnt=%0d ovr=%b required 1/%h/%h/1/0",
                     mem_req_o, mem_wdata_o, mem_addr_o, word_cnt_o, overrun_o, b, BASE + 16'd4);
        end
        tick();
        tests++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== BASE + 16'd8 || word_cnt_o !== 16'd2) begin
            fails++;
            $display("FAIL b2b_done: req=%b addr=%h cnt=%0d required 0/%h/2", mem_req_o, mem_addr_o, word_cnt_o, BASE + 16'd8);
        end
        finish_prog();
        tests++;
        if (wd_q.size() != 2 || wd_q[0] !== a || wd_q[1] !== b || wa_q[1] !== BASE + 16'd4) begin
            fails++;
            $display("FAIL b2b_writes: %0d writes seen, required %h then %h", wd_q.size(), a, b);
        end
        leave_prog();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, c;
        a = rand_word(); c = rand_word();
        cfg_we_i = 1'b1; cfg_cpb_i = 16'd1000;
        tick();
        cfg_we_i = 1'b0;
        mem_gnt_i = 1'b0;
        enter_prog();
        send_word(a, 0);
        send_byte(8'h5A);
        send_byte(8'hC3);
        tests++;
        if (mem_req_o !== 1'b1) begin
            fails++;
            $display("FAIL mid_req_pending: req=%b required 1", mem_req_o);
        end
        #2;
        rst_ni = 1'b0;
        prog_en_i = 1'b0;
        #1;
        tests++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== BASE || mem_wdata_o !== 32'h0 || clks_per_bit_o !== DEF_CPB ||
            core_rst_no !== 1'b0 || busy_o !== 1'b0 || word_cnt_o !== '0) begin
            fails++;
            $display("FAIL async_reset: req=%b addr=%h data=%h cpb=%0d crst=%b busy=%b cnt=%0d",
                     mem_req_o, mem_addr_o, mem_wdata_o, clks_per_bit_o, core_rst_no, busy_o, word_cnt_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        mem_gnt_i = 1'b1;
        enter_prog();
        send_word(c, 1);
        tick();
        finish_prog();
        tests++;
        if (wd_q.size() != 1 || wd_q[0] !== c || wa_q[0] !== BASE) begin
            fails++;
            $display("FAIL after_reset_lane0: %0d writes seen, required one of %h at %h", wd_q.size(), c, BASE);
        end
        leave_prog();
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_single_word();
        for (int r = 0; r < 4; r++) test_program($urandom_range(3, 6));
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
